// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1:N packet stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam int DROP_CNT_W = 16;

  // Select width, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_1_n_slot.sv
// One-entry valid/ready output register for a single demux channel.
module demux_out_slot #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  // A load only arrives when the slot is empty or draining, so data never changes under a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_n.sv
// 1:N packet demux: routes each packet to the channel chosen on its first beat.
module stream_demux_1_n
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  localparam int SELW = sel_w(N_OUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  input  logic [SELW-1:0]       s_sel,
  input  logic                  s_last,
  output logic [N_OUT-1:0]      m_valid,
  input  logic [N_OUT-1:0]      m_ready,
  output logic [N_OUT*DW-1:0]   m_data,
  output logic [N_OUT-1:0]      m_last,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  busy
);

  state_e          state, state_nx;
  logic [SELW-1:0] locked_sel;
  logic [SELW-1:0] cur;
  logic [31:0]     cur_ext;
  logic            route_ok;
  logic            acc;
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] load;

  assign cur      = (state == IDLE) ? s_sel : locked_sel;
  assign cur_ext  = 32'(cur);
  assign route_ok = (state != DROP) && (cur_ext < 32'(N_OUT));

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) hit[k] = (cur_ext == 32'(k));
  end

  // Discarded beats are always accepted; routed beats wait only on their own slot.
  assign s_ready = !route_ok || (|(hit & (~m_valid | m_ready)));
  assign acc     = s_valid && s_ready;
  assign load    = (acc && route_ok) ? hit : '0;
  assign busy    = (state != IDLE) || (|m_valid);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (acc && !s_last) state_nx = route_ok ? ROUTE : DROP;
      ROUTE, DROP: if (acc && s_last)  state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      locked_sel <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (acc && state == IDLE) begin
        locked_sel <= s_sel;
        if (!route_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_out_slot #(.W(DW + 1)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   ({s_last, s_data}),
      .ready (m_ready[k]),
      .valid (m_valid[k]),
      .dout  ({m_last[k], m_data[k*DW +: DW]})
    );
  end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Directed and randomized checks of stream_demux_1_n against a slot-level reference model.
module tb_stream_demux_1_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        s_valid = 0, s_last = 0, s_ready;
  logic [7:0]  s_data = 0;
  logic [1:0]  s_sel = 0;
  logic [3:0]  m_valid, m_ready = 4'hF, m_last;
  logic [31:0] m_data;
  logic [15:0] drop_cnt;
  logic        busy;

  // 3-channel instance, used for out-of-range selects
  logic        d_valid = 0, d_last = 0, d_ready;
  logic [7:0]  d_data = 0;
  logic [1:0]  d_sel = 0;
  logic [2:0]  d_m_valid, d_m_ready = 3'b111, d_m_last;
  logic [23:0] d_m_data;
  logic [15:0] d_drop_cnt;
  logic        d_busy;

  int n_chk = 0, n_err = 0;

  stream_demux_1_n #(.N_OUT(4), .DW(8)) u4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sel(s_sel), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .drop_cnt(drop_cnt), .busy(busy)
  );

  stream_demux_1_n #(.N_OUT(3), .DW(8)) u3 (
    .clk(clk), .rst_n(rst_n), .s_valid(d_valid), .s_ready(d_ready), .s_data(d_data),
    .s_sel(d_sel), .s_last(d_last), .m_valid(d_m_valid), .m_ready(d_m_ready), .m_data(d_m_data),
    .m_last(d_m_last), .drop_cnt(d_drop_cnt), .busy(d_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: one-entry slot per channel plus packet-in-progress tracking.
  bit         occ [4];
  logic [8:0] val [4];
  bit         in_pkt;
  int         dest;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_m_valid", 32'(m_valid), 0);
    chk("post_rst_drop_cnt", 32'(drop_cnt), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Single-beat packets to each channel
    for (int sel = 0; sel < 4; sel++) begin
      s_valid = 1; s_sel = 2'(sel); s_data = 8'(8'hA0 + sel); s_last = 1;
      #1 chk("single_s_ready", 32'(s_ready), 1);
      step();
      s_valid = 0;
      chk("single_m_valid", 32'(m_valid), 32'(1 << sel));
      chk("single_m_data", 32'(m_data[sel*8 +: 8]), 32'(8'hA0 + sel));
      chk("single_m_last", 32'(m_last[sel]), 1);
    end
    step();
    chk("single_drained", 32'(m_valid), 0);

    // Select is locked for the whole packet
    for (int b = 0; b < 3; b++) begin
      s_valid = 1; s_sel = (b == 0) ? 2'd2 : 2'd1; s_data = 8'(8'h50 + b); s_last = (b == 2);
      step();
      chk("lock_m_valid", 32'(m_valid), 32'h4);
      chk("lock_m_data", 32'(m_data[23:16]), 32'(8'h50 + b));
      chk("lock_m_last", 32'(m_last[2]), 32'(b == 2));
    end
    s_valid = 0; s_last = 0;
    step();
    chk("lock_idle_busy", 32'(busy), 0);

    // Backpressure on channel 1
    m_ready = 4'b1101;
    s_valid = 1; s_sel = 2'd1; s_data = 8'h61; s_last = 0;
    step();
    s_data = 8'h62; s_last = 1; s_sel = 2'd3;
    #1 chk("bp_s_ready_low", 32'(s_ready), 0);
    chk("bp_beat1_data", 32'(m_data[15:8]), 32'h61);
    step();
    chk("bp_hold_valid", 32'(m_valid), 32'h2);
    chk("bp_hold_data", 32'(m_data[15:8]), 32'h61);
    chk("bp_hold_last", 32'(m_last[1]), 0);
    chk("bp_busy", 32'(busy), 1);
    m_ready = 4'hF;
    #1 chk("bp_s_ready_comb", 32'(s_ready), 1);
    step();
    s_valid = 0; s_last = 0;
    chk("bp_beat2_valid", 32'(m_valid), 32'h2);
    chk("bp_beat2_data", 32'(m_data[15:8]), 32'h62);
    chk("bp_beat2_last", 32'(m_last[1]), 1);
    step();
    chk("bp_drained", 32'(m_valid), 0);

    // Drop on the 3-channel instance; later beats carry an in-range select
    for (int b = 0; b < 4; b++) begin
      d_valid = 1; d_sel = (b == 0) ? 2'd3 : 2'd0; d_data = 8'(8'h30 + b); d_last = (b == 3);
      #1 chk("drop_s_ready", 32'(d_ready), 1);
      step();
      chk("drop_no_valid", 32'(d_m_valid), 0);
    end
    chk("drop_cnt_one", 32'(d_drop_cnt), 1);
    d_valid = 1; d_sel = 2'd0; d_data = 8'h77; d_last = 1;
    step();
    d_valid = 0;
    chk("after_drop_valid", 32'(d_m_valid), 32'h1);
    chk("after_drop_data", 32'(d_m_data[7:0]), 32'h77);
    chk("after_drop_cnt", 32'(d_drop_cnt), 1);

    // Reset in the middle of a 5-beat packet
    for (int b = 0; b < 2; b++) begin
      s_valid = 1; s_sel = 2'd0; s_data = 8'(8'h80 + b); s_last = 0;
      step();
    end
    rst_n = 0; s_valid = 0;
    #1 chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    step(); step();
    rst_n = 1;
    step();
    s_valid = 1; s_sel = 2'd3; s_data = 8'h93; s_last = 1;
    step();
    s_valid = 0; s_last = 0;
    chk("midrst_new_valid", 32'(m_valid), 32'h8);
    chk("midrst_new_data", 32'(m_data[31:24]), 32'h93);
    step();

    // Randomized traffic against the reference model
    for (int k = 0; k < 4; k++) begin occ[k] = 0; val[k] = '0; end
    in_pkt = 0; dest = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int   c;
      bit   er;
      logic [3:0] ev;
      s_valid = ($urandom_range(0, 3) != 0);
      s_sel   = 2'($urandom_range(0, 3));
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 2) == 0);
      m_ready = 4'($urandom);
      #1;
      c  = in_pkt ? dest : int'(s_sel);
      er = !occ[c] || m_ready[c];
      for (int k = 0; k < 4; k++) ev[k] = occ[k];
      chk("rnd_m_valid", 32'(m_valid), 32'(ev));
      chk("rnd_s_ready", 32'(s_ready), 32'(er));
      chk("rnd_busy", 32'(busy), 32'(in_pkt || (ev != 0)));
      for (int k = 0; k < 4; k++)
        if (occ[k]) chk("rnd_m_beat", 32'({m_last[k], m_data[k*8 +: 8]}), 32'(val[k]));
      for (int k = 0; k < 4; k++) if (m_ready[k]) occ[k] = 0;
      if (s_valid && er) begin
        occ[c] = 1;
        val[c] = {s_last, s_data};
        if (!in_pkt && !s_last) begin in_pkt = 1; dest = c; end
        else if (in_pkt && s_last) in_pkt = 0;
      end
      step();
    end
    s_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
